// File: rtl/bist_pattern_driver.sv
// Logic-BIST pattern driver: a 20-bit LFSR feeds a combinational CUT and a 24-bit MISR compacts its responses.
// Optional signature comparator on pass_o is enabled by defining BIST_SIG_COMPARE_EN.
module bist_pattern_driver #(
  parameter int unsigned NUM_PATTERNS = 256,
  parameter logic [19:0] LFSR_SEED    = 20'h00001,
  parameter logic [23:0] EXP_SIG      = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  output logic [19:0] pat_o,
  input  logic [23:0] resp_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [23:0] sig_o,
  output logic        pass_o
);

  localparam int unsigned SIG_W    = $bits(EXP_SIG);
  // An all-zero LFSR would lock up, so a zero seed falls back to 1.
  localparam logic [19:0] SEED_EFF = (LFSR_SEED == 20'h00000) ? 20'h00001 : LFSR_SEED;
  localparam logic [15:0] TERM_CNT = 16'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [19:0]        r_lfsr;
  logic [SIG_W-1:0]   r_misr;
  logic [15:0]        r_cnt;
  logic               w_load;
  logic               w_last;
  logic               w_step;
  logic [19:0]        w_lfsr_next;
  logic [SIG_W-1:0]   w_misr_next;

  assign w_last      = (r_cnt == TERM_CNT);
  assign w_step      = (r_state == RUN) && !abort_i;
  assign w_lfsr_next = {r_lfsr[18:0], r_lfsr[19] ^ r_lfsr[16]};
  assign w_misr_next = {r_misr[22:0], r_misr[23] ^ r_misr[22] ^ r_misr[21] ^ r_misr[16]} ^ resp_i;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (start_i) begin
          w_state_next = RUN;
          w_load       = 1'b1;
        end
      end
      RUN: begin
        if (w_last) w_state_next = DONE;
      end
      default: w_state_next = IDLE;
    endcase
    if (abort_i) begin
      w_state_next = IDLE;
      w_load       = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_lfsr  <= SEED_EFF;
      r_misr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_lfsr <= SEED_EFF;
        r_misr <= '0;
        r_cnt  <= '0;
      end else if (w_step) begin
        r_lfsr <= w_lfsr_next;
        r_misr <= w_misr_next;
        // Counter parks at terminal count rather than wrapping.
        if (!w_last) r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign busy_o = (r_state == RUN);
  assign done_o = (r_state == DONE);
  assign pat_o  = busy_o ? r_lfsr : 20'h00000;
  assign sig_o  = r_misr;

`ifdef BIST_SIG_COMPARE_EN
  logic r_pass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass <= 1'b0;
    end else if (abort_i || w_load) begin
      r_pass <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_pass <= (w_misr_next == EXP_SIG);
    end
  end

  assign pass_o = r_pass;
`else
  assign pass_o = 1'b0;
`endif

endmodule

// File: doc/bist_pattern_driver.md
BIST_PATTERN_DRIVER -- requirements
Module: bist_pattern_driver

Interface
REQ-001 SHALL have parameter NUM_PATTERNS, default 256, meaning the number of patterns applied per run (legal range 1..65535).
REQ-002 SHALL have parameter LFSR_SEED, default 20'h00001, meaning the initial stimulus LFSR value.
REQ-003 SHALL have parameter EXP_SIG, default 24'h000000, meaning the golden MISR signature.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, meaning the asynchronous, active-low reset.
REQ-006 SHALL have port start_i, input, 1 bit, meaning request to begin a run.
REQ-007 SHALL have port abort_i, input, 1 bit, meaning synchronous cancel of a run.
REQ-008 SHALL have port pat_o, output, 20 bits, meaning the stimulus driven to the 20 primary inputs of the combinational circuit under test (CUT).
REQ-009 SHALL have port resp_i, input, 24 bits, meaning the 24 CUT primary outputs.
REQ-010 SHALL have port busy_o, output, 1 bit, meaning a run is in progress.
REQ-011 SHALL have port done_o, output, 1 bit, meaning the last run completed.
REQ-012 SHALL have port sig_o, output, 24 bits, meaning the current MISR signature.
REQ-013 SHALL have port pass_o, output, 1 bit, meaning the signature matches EXP_SIG.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE, with the following transitions: IDLE->RUN on start_i; RUN->DONE after NUM_PATTERNS cycles; DONE->RUN on start_i; any state->IDLE on abort_i.
REQ-015 SHALL, on accepting start_i in IDLE or DONE, load the LFSR with LFSR_SEED (or 20'h00001 if LFSR_SEED==0), clear the MISR and pattern counter, and clear done_o.
REQ-016 SHALL, in RUN, drive pat_o=LFSR and, each cycle, update LFSR <= {LFSR[18:0], LFSR[19]^LFSR[16]}.
REQ-017 SHALL, in RUN, sample resp_i in the same cycle pat_o is presented (CUT is combinational, zero-cycle latency).
REQ-018 SHALL, in RUN, update the MISR each cycle as MISR <= {MISR[22:0], MISR[23]^MISR[22]^MISR[21]^MISR[16]} ^ resp_i.
REQ-019 SHALL hold busy_o high for exactly NUM_PATTERNS cycles per run; if start_i is sampled at edge k, done_o SHALL rise after edge k+NUM_PATTERNS and hold until the next start or abort.
REQ-020 SHALL ignore start_i while in RUN.
REQ-021 SHALL give abort_i priority over start_i when both are asserted in the same cycle.
REQ-022 SHALL, on abort, go to IDLE with busy_o=0 and done_o=0, freeze sig_o at its current value, and drive pat_o=0.
REQ-023 SHALL drive pat_o=0 in IDLE and DONE, and hold sig_o stable in IDLE and DONE.
REQ-024 SHALL use a 16-bit pattern counter, with terminal count NUM_PATTERNS-1, and SHALL not wrap within a run.

Reset
REQ-025 SHALL, while rst_n=0, force the FSM to IDLE, LFSR=LFSR_SEED (or 1 if LFSR_SEED==0), MISR=0, counter=0, and outputs pat_o=0, busy_o=0, done_o=0, sig_o=0, pass_o=0, regardless of clk.
REQ-026 SHALL, on reset asserted mid-run, discard the run entirely; after release, a new start_i is required.

Configuration
REQ-027 SHALL, with macro BIST_SIG_COMPARE_EN defined, register pass_o = done_o && (MISR==EXP_SIG), updated with done_o and cleared on start, abort or reset.
REQ-028 SHALL, without BIST_SIG_COMPARE_EN, tie pass_o to 0, omit the comparator, and leave EXP_SIG unused.

Verification
REQ-029 SHALL cover: NUM_PATTERNS=1, resp_i=24'hFFFFFF, pulse start -> busy_o for 1 cycle, then done_o=1 and sig_o=24'hFFFFFF.
REQ-030 SHALL cover: NUM_PATTERNS=2, resp_i=24'hFFFFFF -> sig_o=24'h000001 at done.
REQ-031 SHALL cover: LFSR_SEED=1, NUM_PATTERNS=20 -> pat_o sequence 00001, 00002, ..., 10000, then 20001, 40002.
REQ-032 SHALL cover: abort_i asserted on the 5th RUN cycle together with start_i -> IDLE next cycle, busy_o=0, done_o=0, pat_o=0; a later start re-runs from the seed.
REQ-033 SHALL cover: rst_n pulsed low mid-run (asynchronously, between edges) -> all outputs 0 immediately; start_i ignored during reset.
REQ-034 SHALL cover: with BIST_SIG_COMPARE_EN and EXP_SIG=24'h000001, the REQ-030 stimulus -> pass_o=1; with resp_i=0, the same run -> pass_o=0.
